// File: rtl/weight_mem_pkg.sv
// Shared types and constants for the weight memory read responder.
package weight_mem_pkg;
   localparam int BURST_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/weight_sram.sv
// DEPTH x DW store, one write port and one synchronous read port.
// Latency: read data valid the cycle after rd_en; same-cycle write/read returns old data.
// Backpressure: none, the caller only reads when it can absorb the result.
module weight_sram #(
   parameter int DW    = 32,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DW-1:0]            wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DW-1:0]            rd_data
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/weight_mem_responder.sv
// Burst read responder over a preloadable weight store.
// Latency: first beat 2 cycles after the request handshake, then one beat per cycle.
// Backpressure: rready stalls via a 2-entry skid stage; reads issue only when it has room.
module weight_mem_responder
   import weight_mem_pkg::*;
#(
   parameter int DW    = 32,
   parameter int AW    = 32,
   parameter int DEPTH = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [AW-1:0]            araddr,
   input  logic                     arvalid,
   input  logic [BURST_W-1:0]       arburst,
   output logic                     arready,
   output logic [DW-1:0]            rdata,
   output logic                     rvalid,
   input  logic                     rready,
   output logic                     rlast,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DW-1:0]            wr_data
);
   localparam int PW = $clog2(DEPTH);

   state_t           state_q, state_d;
   logic [PW-1:0]    ptr_q;
   logic [BURST_W:0] remain_q;
   logic             run_q;
   logic             pipe_vld_q, pipe_last_q;
   logic [DW-1:0]    sram_dout;
   logic [DW-1:0]    skid_dat_q  [2];
   logic             skid_last_q [2];
   logic             skid_wp_q, skid_rp_q;
   logic [1:0]       skid_cnt_q, skid_cnt_d;
   logic             skid_empty, skid_push, skid_pop;
   logic             ar_hs, issue, beat_take, out_last, last_issue;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{araddr[AW-1:PW+2], araddr[1:0]};

   // Skid entries take priority; the SRAM output is bypassed only when they are empty.
   assign skid_empty = (skid_cnt_q == 2'd0);
   assign rvalid     = !skid_empty || pipe_vld_q;
   assign out_last   = skid_empty ? pipe_last_q : skid_last_q[skid_rp_q];
   assign rlast      = rvalid && out_last;
   assign rdata      = !rvalid ? '0 : (skid_empty ? sram_dout : skid_dat_q[skid_rp_q]);
   assign beat_take  = rvalid && rready;
   assign skid_push  = pipe_vld_q && !(skid_empty && rready);
   assign skid_pop   = !skid_empty && rready;
   assign skid_cnt_d = skid_cnt_q + {1'b0, skid_push} - {1'b0, skid_pop};

   // A new read lands in the pipe next cycle, so the skid must keep one slot for it.
   assign issue      = (state_q == ST_BURST) && (skid_cnt_d <= 2'd1);
   assign last_issue = issue && (remain_q == (BURST_W+1)'(1));
   assign arready    = (state_q == ST_IDLE) && run_q;
   assign ar_hs      = arvalid && arready;

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (ar_hs) state_d = ST_BURST;
         ST_BURST: if (last_issue) state_d = ST_DRAIN;
         ST_DRAIN: if (beat_take && rlast) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         run_q       <= 1'b0;
         ptr_q       <= '0;
         remain_q    <= '0;
         pipe_vld_q  <= 1'b0;
         pipe_last_q <= 1'b0;
         skid_wp_q   <= 1'b0;
         skid_rp_q   <= 1'b0;
         skid_cnt_q  <= 2'd0;
         for (int i = 0; i < 2; i++) begin
            skid_dat_q[i]  <= '0;
            skid_last_q[i] <= 1'b0;
         end
      end else begin
         state_q     <= state_d;
         run_q       <= 1'b1;
         pipe_vld_q  <= issue;
         pipe_last_q <= last_issue;
         skid_cnt_q  <= skid_cnt_d;
         if (ar_hs) begin
            ptr_q    <= araddr[PW+1:2];
            remain_q <= {1'b0, arburst} + (BURST_W+1)'(1);
         end else if (issue) begin
            ptr_q    <= ptr_q + PW'(1);
            remain_q <= remain_q - (BURST_W+1)'(1);
         end
         if (skid_push) begin
            skid_dat_q[skid_wp_q]  <= sram_dout;
            skid_last_q[skid_wp_q] <= pipe_last_q;
            skid_wp_q              <= ~skid_wp_q;
         end
         if (skid_pop) skid_rp_q <= ~skid_rp_q;
      end
   end

   weight_sram #(
      .DW    (DW),
      .DEPTH (DEPTH)
   ) u_sram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_en   (issue),
      .rd_addr (ptr_q),
      .rd_data (sram_dout)
   );
endmodule

// File: tb/tb_weight_mem_responder.sv
// Directed bench for weight_mem_responder: latency, bursts, wrap, stalls, reset, collision.
module tb_weight_mem_responder;
   localparam int DW    = 32;
   localparam int AW    = 32;
   localparam int DEPTH = 1024;
   localparam int PW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [AW-1:0] araddr = '0;
   logic          arvalid = 1'b0;
   logic [3:0]    arburst = '0;
   logic          arready;
   logic [DW-1:0] rdata;
   logic          rvalid;
   logic          rready = 1'b1;
   logic          rlast;
   logic          wr_en = 1'b0;
   logic [PW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;

   logic [DW-1:0] mdl [DEPTH];
   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   weight_mem_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk     (clk),
      .rst     (rst),
      .araddr  (araddr),
      .arvalid (arvalid),
      .arburst (arburst),
      .arready (arready),
      .rdata   (rdata),
      .rvalid  (rvalid),
      .rready  (rready),
      .rlast   (rlast),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wr(input int a, input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_addr = PW'(a);
      wr_data = d;
      mdl[a]  = d;
      @(posedge clk); #1;
      wr_en   = 1'b0;
   endtask

   // mode 0: rready held high; mode 1: rready pattern 1,0,0 repeating.
   // abort > 0 stops collecting after that many beats (left mid-burst).
   task automatic run_burst(input logic [AW-1:0] addr, input int arb, input int mode, input int abort);
      int beats = 0;
      int cyc   = 0;
      int w0;
      logic held = 1'b0;
      logic [DW-1:0] held_d = '0;
      logic held_l = 1'b0;
      logic done = 1'b0;
      w0 = int'(addr >> 2) % DEPTH;
      @(posedge clk); #1;
      arvalid = 1'b1;
      araddr  = addr;
      arburst = 4'(arb);
      rready  = (mode == 0);
      @(negedge clk);
      check("arready_idle", arready, 1);
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      check("rvalid_early", rvalid, 0);
      while (!done && cyc < 200) begin
         @(posedge clk); #1;
         rready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         cyc++;
         @(negedge clk);
         if (mode == 0) check("rvalid_nogap", rvalid, 1);
         if (held) begin
            check("hold_vld", rvalid, 1);
            check("hold_dat", rdata, held_d);
            check("hold_last", rlast, held_l);
         end
         held = 1'b0;
         if (rvalid && rready) begin
            check("rdata", rdata, mdl[(w0 + beats) % DEPTH]);
            check("rlast", rlast, beats == arb);
            if (beats == arb) check("arready_busy", arready, 0);
            beats++;
            if (beats == arb + 1 || (abort > 0 && beats == abort)) done = 1'b1;
         end else if (rvalid) begin
            held   = 1'b1;
            held_d = rdata;
            held_l = rlast;
         end
      end
      if (abort > 0) begin
         check("beats_before_abort", beats, abort);
      end else begin
         check("beat_count", beats, arb + 1);
         @(posedge clk);
         @(negedge clk);
         check("arready_after", arready, 1);
         check("rvalid_after", rvalid, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_arready", arready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_rlast", rlast, 0);
      check("rst_rdata", rdata, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("arready_post_rst", arready, 1);

      // single word: word 5 at byte 0x14
      wr(5, 32'hA5A5_0005);
      check("model_w5", mdl[5], 32'hA5A5_0005);
      run_burst(32'h14, 0, 0, 0);

      for (int i = 0; i < DEPTH; i++) wr(i, DW'(i));
      run_burst(32'h0, 15, 0, 0);
      run_burst(AW'((DEPTH - 2) * 4), 3, 0, 0);
      run_burst(32'h40, 7, 1, 0);

      // reset after beat 3 of a 16-beat burst
      run_burst(32'h0, 15, 0, 3);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("rst_mid_rvalid", rvalid, 0);
      check("rst_mid_rdata", rdata, 0);
      check("rst_mid_arready", arready, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      check("rst_mid_arready_rel", arready, 1);
      run_burst(32'h20, 3, 0, 0);

      // write to word 2 in the cycle its burst read issues
      fork
         run_burst(32'h0, 3, 0, 0);
         begin
            @(posedge clk); #1;
            repeat (3) @(posedge clk);
            #1;
            wr_en   = 1'b1;
            wr_addr = PW'(2);
            wr_data = 32'hDEAD_0002;
            @(posedge clk); #1;
            wr_en   = 1'b0;
         end
      join
      mdl[2] = 32'hDEAD_0002;
      run_burst(32'h8, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
